// File: rtl/gpt_pkg.sv
// rtl/gpt_pkg.sv - shared constants and types for the general-purpose timer time base
// Contents: default counter width, STOP/RUN state enum, count-direction constants.
package gpt_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } tbu_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/time_base_unit_if.sv
// rtl/time_base_unit_if.sv - control/status bundle of the timer time base
// master: controller side (drives slave-mode, register and pulse inputs; reads status).
// slave : time base side (receives controls; drives cnt/cen/uev/uif).
interface time_base_unit_if #(
  parameter int CNT_W = gpt_pkg::CNT_W_DEF
);
  logic             cnt_tick;
  logic             sm_reset;
  logic             gate_mode;
  logic             sm_gate;
  logic             sm_trig;
  logic             cen_we;
  logic             cen_wdata;
  logic             opm;
  logic             dir;
  logic             arpe;
  logic             udis;
  logic             urs;
  logic             ug;
  logic [CNT_W-1:0] psc;
  logic [CNT_W-1:0] arr;
  logic             uif_clr;
  logic [CNT_W-1:0] cnt;
  logic             cen;
  logic             uev;
  logic             uif;

  modport master (
    output cnt_tick, sm_reset, gate_mode, sm_gate, sm_trig, cen_we, cen_wdata,
           opm, dir, arpe, udis, urs, ug, psc, arr, uif_clr,
    input  cnt, cen, uev, uif
  );

  modport slave (
    input  cnt_tick, sm_reset, gate_mode, sm_gate, sm_trig, cen_we, cen_wdata,
           opm, dir, arpe, udis, urs, ug, psc, arr, uif_clr,
    output cnt, cen, uev, uif
  );

endinterface

// File: rtl/time_base_unit_prescaler.sv
// rtl/time_base_unit_prescaler.sv - prescaler counter with shadowed ratio
// Ports: clk_i, rst_i; step_en_i (qualified tick), reinit_i (clear count),
//        load_i (update event: latch psc_i into shadow), psc_i (ratio-1),
//        cnt_step_o (one counter step per psc_sh+1 step enables).
module tb_prescaler
  import gpt_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_en_i,
  input  logic             reinit_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] psc_i,
  output logic             cnt_step_o
);

  localparam logic [CNT_W-1:0] PSC_ONE = CNT_W'(1);

  logic [CNT_W-1:0] psc_cnt_q, psc_cnt_d;
  logic [CNT_W-1:0] psc_sh_q, psc_sh_d;
  logic             psc_hit;

  assign psc_hit    = (psc_cnt_q == psc_sh_q);
  // A reinit in the same cycle swallows the step so the counter restarts cleanly.
  assign cnt_step_o = step_en_i & psc_hit & ~reinit_i;

  always_comb begin
    psc_cnt_d = psc_cnt_q;
    psc_sh_d  = psc_sh_q;
    if (reinit_i) begin
      psc_cnt_d = '0;
    end else if (step_en_i) begin
      psc_cnt_d = psc_hit ? '0 : psc_cnt_q + PSC_ONE;
    end
    if (load_i) begin
      psc_sh_d = psc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psc_cnt_q <= '0;
      psc_sh_q  <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
      psc_sh_q  <= psc_sh_d;
    end
  end

endmodule

// File: rtl/time_base_unit.sv
// rtl/time_base_unit.sv - timer time base: run control, prescaler, up/down counter, update events
// Ports: clk_i/rst_i; slave-mode inputs (cnt_tick_i, sm_reset_i, gate_mode_i, sm_gate_i, sm_trig_i);
//        control (cen_we_i, cen_wdata_i, opm_i, dir_i, arpe_i, udis_i, urs_i, ug_i, psc_i, arr_i, uif_clr_i);
//        status (cnt_o, cen_o, uev_o, uif_o), all registered.
module time_base_unit
  import gpt_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cnt_tick_i,
  input  logic             sm_reset_i,
  input  logic             gate_mode_i,
  input  logic             sm_gate_i,
  input  logic             sm_trig_i,
  input  logic             cen_we_i,
  input  logic             cen_wdata_i,
  input  logic             opm_i,
  input  logic             dir_i,
  input  logic             arpe_i,
  input  logic             udis_i,
  input  logic             urs_i,
  input  logic             ug_i,
  input  logic [CNT_W-1:0] psc_i,
  input  logic [CNT_W-1:0] arr_i,
  input  logic             uif_clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             cen_o,
  output logic             uev_o,
  output logic             uif_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  tbu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] arr_sh_q, arr_sh_d;
  logic             uev_q, uev_d;
  logic             uif_q, uif_d;

  logic             step_en;
  logic             cnt_step;
  logic             reinit;
  logic             wrap;
  logic             uev_evt;
  logic [CNT_W-1:0] arr_eff;

  assign reinit  = ug_i | sm_reset_i;
  assign step_en = (state_q == ST_RUN) & cnt_tick_i & (~gate_mode_i | sm_gate_i);
  assign arr_eff = arpe_i ? arr_sh_q : arr_i;

  tb_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .step_en_i  (step_en),
    .reinit_i   (reinit),
    .load_i     (uev_evt),
    .psc_i      (psc_i),
    .cnt_step_o (cnt_step)
  );

  // Counter datapath; a zero auto-reload value parks the counter.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (reinit) begin
      cnt_d = (dir_i == DIR_DOWN) ? arr_eff : '0;
    end else if (cnt_step && (arr_eff != '0)) begin
      if (dir_i == DIR_UP) begin
        if (cnt_q == arr_eff) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d = arr_eff;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end
  end

  // Update event: all sources merge into one pulse; udis blocks the event but not the reinit.
  always_comb begin
    uev_evt  = (wrap | reinit) & ~udis_i;
    uev_d    = uev_evt;
    arr_sh_d = uev_evt ? arr_i : arr_sh_q;
    uif_d    = uif_q;
    if (uev_evt && (!urs_i || wrap)) begin
      uif_d = 1'b1;
    end else if (uif_clr_i) begin
      uif_d = 1'b0;
    end
  end

  // Run control: OPM wrap stop beats a cen write, which beats a trigger.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (cen_we_i) begin
          state_d = cen_wdata_i ? ST_RUN : ST_STOP;
        end else if (sm_trig_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (opm_i && wrap) begin
          state_d = ST_STOP;
        end else if (cen_we_i && !cen_wdata_i) begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_STOP;
      cnt_q    <= '0;
      arr_sh_q <= '1;
      uev_q    <= 1'b0;
      uif_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      arr_sh_q <= arr_sh_d;
      uev_q    <= uev_d;
      uif_q    <= uif_d;
    end
  end

  assign cnt_o = cnt_q;
  assign cen_o = (state_q == ST_RUN);
  assign uev_o = uev_q;
  assign uif_o = uif_q;

endmodule
